// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner.
//   clog2_min1    : index width helper, never less than one bit
//   SEG_OFF       : all segments dark (active-low)
//   AN_ACTIVE_LOW : anode drive polarity of the board
//   blink_phase_e : visible/dark half of the blink period
package seven_seg_scanner_pkg;

  localparam logic [6:0] SEG_OFF       = 7'h7F;
  localparam bit         AN_ACTIVE_LOW = 1'b1;

  typedef enum logic {
    PHASE_VISIBLE = 1'b0,
    PHASE_DARK    = 1'b1
  } blink_phase_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational hex-to-seven-segment decoder.
//   hex : 4-bit value 0..F
//   seg : segment pattern {g,f,e,d,c,b,a}, active-low
module hex_to_seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = ~7'h3F;
      4'h1: seg = ~7'h06;
      4'h2: seg = ~7'h5B;
      4'h3: seg = ~7'h4F;
      4'h4: seg = ~7'h66;
      4'h5: seg = ~7'h6D;
      4'h6: seg = ~7'h7D;
      4'h7: seg = ~7'h07;
      4'h8: seg = ~7'h7F;
      4'h9: seg = ~7'h6F;
      4'hA: seg = ~7'h77;
      4'hB: seg = ~7'h7C;
      4'hC: seg = ~7'h39;
      4'hD: seg = ~7'h5E;
      4'hE: seg = ~7'h79;
      4'hF: seg = ~7'h71;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Inputs are shadowed once per frame so a frame never mixes old and new data.
//   clk, reset   : system clock, asynchronous active-high reset
//   digits       : hex values, [3:0] is digit 0 (rightmost)
//   dp_en        : decimal point request per digit
//   blank        : force digit dark
//   blink        : digit follows the blink phase
//   lz_suppress  : suppress leading zeros (digit 0 always shown)
//   enable       : 0 turns all anodes off, scanning continues
//   seg, dp, an  : registered active-low display pins
//   frame_tick   : one-cycle pulse per frame boundary
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_suppress,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned SW = clog2_min1(NUM_DIGITS);
  localparam int unsigned PW = clog2_min1(REFRESH_DIV);
  localparam int unsigned FW = clog2_min1(BLINK_FRAMES);

  localparam logic [SW-1:0] S_LAST = SW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]           p;
  logic [SW-1:0]           s;
  logic [FW-1:0]           fc;
  blink_phase_e            phase;
  logic                    load_pending;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic [NUM_DIGITS-1:0]   sh_lz;

  logic [NUM_DIGITS-1:0]   lz_next;
  logic                    leading;
  logic [3:0]              cur_digit;
  logic                    cur_dp, cur_blank, cur_blink, cur_lz;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              cur_seg;
  logic                    p_last, frame_end, dark;

  assign p_last    = (p == P_LAST);
  assign frame_end = p_last && (s == S_LAST);

  // Leading-zero mask with lz_suppress folded in; registered with the shadows.
  always_comb begin
    lz_next = '0;
    leading = lz_suppress;
    for (int unsigned i = NUM_DIGITS; i > 1; i--) begin
      if (leading && digits[4*(i-1) +: 4] == 4'h0) lz_next[i-1] = 1'b1;
      else                                         leading      = 1'b0;
    end
  end

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    onehot    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (s == SW'(i)) begin
        cur_digit = sh_digits[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_blank = sh_blank[i];
        cur_blink = sh_blink[i];
        cur_lz    = sh_lz[i];
        onehot[i] = 1'b1;
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .hex (cur_digit),
    .seg (cur_seg)
  );

  assign dark = !enable || cur_blank || (cur_blink && phase == PHASE_DARK)
              || cur_lz || p_last;
  assign an_next = dark ? '0 : onehot;

  // The first edge after reset only loads the shadows and leaves the outputs
  // dark; counters start on the following edge so slot 0 already shows live data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p            <= '0;
      s            <= '0;
      fc           <= '0;
      phase        <= PHASE_VISIBLE;
      load_pending <= 1'b1;
      sh_digits    <= '0;
      sh_dp        <= '0;
      sh_blank     <= '0;
      sh_blink     <= '0;
      sh_lz        <= '0;
      an           <= AN_OFF;
      seg          <= SEG_OFF;
      dp           <= 1'b1;
      frame_tick   <= 1'b0;
    end else if (load_pending) begin
      load_pending <= 1'b0;
      sh_digits    <= digits;
      sh_dp        <= dp_en;
      sh_blank     <= blank;
      sh_blink     <= blink;
      sh_lz        <= lz_next;
    end else begin
      an         <= AN_ACTIVE_LOW ? ~an_next : an_next;
      seg        <= dark ? SEG_OFF : cur_seg;
      dp         <= dark ? 1'b1 : ~cur_dp;
      frame_tick <= frame_end;

      if (p_last) begin
        p <= '0;
        s <= (s == S_LAST) ? '0 : s + 1'b1;
      end else begin
        p <= p + 1'b1;
      end

      if (frame_end) begin
        sh_digits <= digits;
        sh_dp     <= dp_en;
        sh_blank  <= blank;
        sh_blink  <= blink;
        sh_lz     <= lz_next;
        if (fc == F_LAST) begin
          fc    <= '0;
          phase <= (phase == PHASE_DARK) ? PHASE_VISIBLE : PHASE_DARK;
        end else begin
          fc <= fc + 1'b1;
        end
      end
    end
  end

endmodule
